// File: rtl/in_port_fifo_if.sv
// in_port_fifo_if -- bundle of signals between an external input device,
// the processor's IN instruction and the in_port_fifo buffer.
//
// Parameters: Width (word width), Depth (buffer depth, power of two).
// Modports:
//   slave  -- the buffer itself: takes ext_valid/ext_data/read_enable/
//             flag_clear and drives ext_ready/read_data/data_available/
//             count/overflow/underflow.
//   master -- the environment (device + processor) driving the buffer.
interface in_port_fifo_if #(
    parameter int Width = 16,
    parameter int Depth = 4
);
    localparam int CntW = $clog2(Depth) + 1;

    logic             ext_valid;
    logic [Width-1:0] ext_data;
    logic             ext_ready;
    logic             read_enable;
    logic [Width-1:0] read_data;
    logic             data_available;
    logic [CntW-1:0]  count;
    logic             overflow;
    logic             underflow;
    logic             flag_clear;

    modport slave (
        input  ext_valid, ext_data, read_enable, flag_clear,
        output ext_ready, read_data, data_available, count, overflow, underflow
    );

    modport master (
        output ext_valid, ext_data, read_enable, flag_clear,
        input  ext_ready, read_data, data_available, count, overflow, underflow
    );
endinterface

// File: rtl/in_port_fifo.sv
// in_port_fifo -- circular input buffer between an external device and the
// processor's IN instruction. All state changes on the falling edge of clk.
//
// Ports:
//   clk   -- single clock, state updates on its falling edge
//   reset -- synchronous, active-low; clears pointers, count, read_data, flags
//   io    -- in_port_fifo_if.slave:
//              ext_valid/ext_data/ext_ready : device push handshake
//              read_enable/read_data        : processor pop, read_data holds
//              data_available, count        : occupancy status
//              overflow/underflow/flag_clear: sticky error flags and clear
module in_port_fifo #(
    parameter int Width = 16,
    parameter int Depth = 4
) (
    input  logic            clk,
    input  logic            reset,
    in_port_fifo_if.slave   io
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Width-1:0] read_data_q, read_data_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic ready;
    logic avail;
    logic push;
    logic pop;

    // Handshake status comes only from the registered count, so a push and
    // a pop on the same edge never see each other's effect (no bypass).
    assign ready = (count_q != DepthCnt);
    assign avail = (count_q != '0);
    assign push  = io.ext_valid   && ready;
    assign pop   = io.read_enable && avail;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        read_data_d = read_data_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end

        if (pop) begin
            rd_ptr_d    = next_ptr(rd_ptr_q);
            read_data_d = mem_q[rd_ptr_q];
        end else if (io.read_enable) begin
            // Read on empty: processor sees zero.
            read_data_d = '0;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Clear first, then let a same-edge error event win.
        if (io.flag_clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (io.ext_valid && !ready) begin
            overflow_d = 1'b1;
        end
        if (io.read_enable && !avail) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            read_data_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            read_data_q <= read_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; stale words are unreachable once count is zero.
    always_ff @(negedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= io.ext_data;
        end
    end

    assign io.ext_ready      = ready;
    assign io.data_available = avail;
    assign io.count          = count_q;
    assign io.read_data      = read_data_q;
    assign io.overflow       = overflow_q;
    assign io.underflow      = underflow_q;
endmodule
